// File: rtl/mem_burst_ctrl.sv
// Burst-read / single-write initiator for the shared RW pattern memory port.
// Optional abort input enabled by defining MEM_BURST_CTRL_ABORT_EN.
module mem_burst_ctrl #(
  parameter int word_size    = 8,
  parameter int address_bits = 8,
  parameter int mem_size     = 2**address_bits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [address_bits-1:0] base_add,
  input  logic [address_bits:0]   count,
  output logic                    busy,
  output logic                    done,
  output logic [word_size-1:0]    pat_data,
  output logic                    pat_valid,
  input  logic                    pat_ready,
  input  logic                    wr_req,
  input  logic [address_bits-1:0] wr_add,
  input  logic [word_size-1:0]    wr_data,
  output logic                    wr_ack,
`ifdef MEM_BURST_CTRL_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    mem_en,
  output logic                    mem_rw,
  output logic [0:address_bits-1] mem_add,
  inout  wire  [word_size-1:0]    mem_data
);

  localparam int CW = address_bits + 1;
  // Registered chip enable leaves up to two reads outstanding at issue time,
  // so a third slot is needed to sustain one word per cycle without overflow.
  localparam int unsigned BUF_DEPTH = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [address_bits-1:0] addr_q, addr_d;
  logic [CW-1:0]           rem_q, rem_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_rw_q, mem_rw_d;
  logic [address_bits-1:0] mem_add_q, mem_add_d;
  logic [word_size-1:0]    wdata_q, wdata_d;
  logic                    rdv_q, rdv_d;
  logic                    done_q, done_d;
  logic [word_size-1:0]    buf_q [BUF_DEPTH];
  logic [word_size-1:0]    buf_d [BUF_DEPTH];
  logic [1:0]              occ_q, occ_d;

  logic       abort_i;
  logic       cmd_rd, pop, issue_ok, flush, drain_done;
  logic [2:0] pend;
  logic [1:0] widx;

`ifdef MEM_BURST_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  function automatic logic [address_bits-1:0] next_add(input logic [address_bits-1:0] a);
    return (a == address_bits'(mem_size - 1)) ? '0 : a + address_bits'(1);
  endfunction

  assign cmd_rd   = mem_en_q && !mem_rw_q;
  assign pop      = pat_valid && pat_ready;
  assign pend     = {1'b0, occ_q} + {2'b0, cmd_rd} + {2'b0, rdv_q};
  assign issue_ok = pend < (3'(BUF_DEPTH) + {2'b0, pop});

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mem_en_d   = 1'b0;
    mem_rw_d   = 1'b0;
    mem_add_d  = mem_add_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    drain_done = 1'b0;
    flush      = 1'b0;
    rdv_d      = cmd_rd && !abort_i;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            mem_en_d  = 1'b1;
            mem_add_d = base_add;
            addr_d    = next_add(base_add);
            rem_d     = count - CW'(1);
            state_d   = (count == CW'(1)) ? DRAIN : READ;
          end
        end else if (wr_req) begin
          mem_en_d  = 1'b1;
          mem_rw_d  = 1'b1;
          mem_add_d = wr_add;
          wdata_d   = wr_data;
          state_d   = WRITE;
        end
      end
      READ: begin
        if (abort_i) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (issue_ok) begin
          mem_en_d  = 1'b1;
          mem_add_d = addr_q;
          addr_d    = next_add(addr_q);
          rem_d     = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!cmd_rd && !rdv_q && occ_q == 2'd1 && pop) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-register FIFO: head always at slot 0, push lands behind the survivors.
  always_comb begin
    buf_d = buf_q;
    occ_d = occ_q;
    widx  = occ_q - {1'b0, pop};
    if (flush) begin
      occ_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < BUF_DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
      end
      if (rdv_q) buf_d[widx] = mem_data;
      occ_d = occ_q + {1'b0, rdv_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      mem_en_q  <= 1'b0;
      mem_rw_q  <= 1'b0;
      mem_add_q <= '0;
      wdata_q   <= '0;
      rdv_q     <= 1'b0;
      done_q    <= 1'b0;
      buf_q     <= '{default: '0};
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      mem_en_q  <= mem_en_d;
      mem_rw_q  <= mem_rw_d;
      mem_add_q <= mem_add_d;
      wdata_q   <= wdata_d;
      rdv_q     <= rdv_d;
      done_q    <= done_d;
      buf_q     <= buf_d;
      occ_q     <= occ_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q || drain_done;
  assign pat_valid = (occ_q != '0);
  assign pat_data  = buf_q[0];
  assign wr_ack    = (state_q == WRITE);
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_add   = mem_add_q;
  assign mem_data  = (mem_en_q && mem_rw_q) ? wdata_q : 'z;

endmodule
